// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Monitors a time-multiplexed, active-low seven-segment display bus
// (one-hot-low anodes plus shared cathodes) and recovers the digits shown.
// A digit is accepted once its anode/segment pair has been seen unchanged
// for STABLE_CYCLES samples; once every position has been captured the
// complete frame is published on value/blank/bad with a one-cycle valid.
// Optional build macro: SEG7_HEX_EXT_EN adds the hex letters A..F to the
// decoder; without it those patterns are reported as bad.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     bad,
    output logic                  valid
);

    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   prev_an;
    logic [6:0]          prev_seg;
    logic [7:0]          cnt;

    logic [DIGITS-1:0]   captured;
    logic [4*DIGITS-1:0] work_val;
    logic [DIGITS-1:0]   work_blank;
    logic [DIGITS-1:0]   work_bad;

    logic [DIGITS-1:0]   an_low;
    logic                one_hot;
    logic                same;
    logic                accept;
    logic [6:0]          pat;

    logic [3:0]          dec_nib;
    logic                dec_blank;
    logic                dec_bad;

    logic [4*DIGITS-1:0] next_val;
    logic [DIGITS-1:0]   next_blank;
    logic [DIGITS-1:0]   next_bad;
    logic [DIGITS-1:0]   next_captured;
    logic                frame_done;

    assign an_low  = ~an_q;
    assign one_hot = ($countones(an_low) == 1);
    assign same    = (an_q == prev_an) && (seg_q == prev_seg);
    assign accept  = one_hot && same && (cnt == 8'(STABLE_CYCLES - 1));
    assign pat     = ~seg_q;

    // Register the raw display bus once before any decision is made on it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= '1;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= an;
            seg_q <= seg;
        end
    end

    // Track how long the current anode/segment pair has been held unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_an  <= '1;
            prev_seg <= 7'h7F;
            cnt      <= 8'd0;
        end else if (!one_hot) begin
            cnt <= 8'd0;
        end else if (!same) begin
            prev_an  <= an_q;
            prev_seg <= seg_q;
            cnt      <= 8'd1;
        end else if (cnt != 8'(STABLE_CYCLES)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Translate the active-high segment pattern into a digit nibble
    always_comb begin
        dec_nib   = 4'd0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (pat)
            7'h3F: dec_nib = 4'd0;
            7'h06: dec_nib = 4'd1;
            7'h5B: dec_nib = 4'd2;
            7'h4F: dec_nib = 4'd3;
            7'h66: dec_nib = 4'd4;
            7'h6D: dec_nib = 4'd5;
            7'h7D: dec_nib = 4'd6;
            7'h07: dec_nib = 4'd7;
            7'h7F: dec_nib = 4'd8;
            7'h6F: dec_nib = 4'd9;
            7'h00: dec_blank = 1'b1;
`ifdef SEG7_HEX_EXT_EN
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
`endif
            default: dec_bad = 1'b1;
        endcase
    end

    // Merge an accepted digit into the working frame and detect completion
    always_comb begin
        next_val      = work_val;
        next_blank    = work_blank;
        next_bad      = work_bad;
        next_captured = captured;
        for (int k = 0; k < DIGITS; k++) begin
            if (accept && an_low[k]) begin
                next_val[4*k +: 4] = dec_nib;
                next_blank[k]      = dec_blank;
                next_bad[k]        = dec_bad;
                next_captured[k]   = 1'b1;
            end
        end
        frame_done = accept && (next_captured == {DIGITS{1'b1}});
    end

    // Hold the working frame and publish it once every position is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_val   <= '0;
            work_blank <= '0;
            work_bad   <= '0;
            captured   <= '0;
            value      <= '0;
            blank      <= '0;
            bad        <= '0;
            valid      <= 1'b0;
        end else begin
            work_val   <= next_val;
            work_blank <= next_blank;
            work_bad   <= next_bad;
            valid      <= frame_done;
            if (frame_done) begin
                value    <= next_val;
                blank    <= next_blank;
                bad      <= next_bad;
                captured <= '0;
            end else begin
                captured <= next_captured;
            end
        end
    end

endmodule
